// File: rtl/fetch_pkg.sv
// fetch_pkg
//   Shared types and constants for the instruction fetch front end.
//   - fetch_state_t : fetch controller states (FETCH, HALTED)
//   - HALT_OPCODE   : opcode value in instr[OPCODE_MSB:OPCODE_LSB] that stops fetch
//   - fetch_entry_t : one prefetch queue entry, {pc, instr}
//   - is_halt()     : opcode decode helper
//   Optional feature macro used by the top: FETCH_PERF_CNT_EN.
package fetch_pkg;

  localparam int FETCH_ADDR_W  = 16;
  localparam int FETCH_INSTR_W = 32;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam logic [OPCODE_MSB-OPCODE_LSB:0] HALT_OPCODE = 6'b111111;

  typedef enum logic {
    FETCH  = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [FETCH_ADDR_W-1:0]  pc;
    logic [FETCH_INSTR_W-1:0] instr;
  } fetch_entry_t;

  function automatic logic is_halt(input logic [FETCH_INSTR_W-1:0] instr);
    return instr[OPCODE_MSB:OPCODE_LSB] == HALT_OPCODE;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue
//   Synchronous FIFO of fetch_entry_t used as the fetch prefetch buffer.
//   Ports:
//     clk, rst_n  : clock, asynchronous active-low reset
//     push        : write push_data (ignored when full without a pop, or on flush)
//     push_data   : entry to write
//     pop         : remove head (ignored when empty)
//     flush       : discard all entries; wins over push
//     head        : current head entry (stale when empty)
//     full, empty : occupancy flags
//   DEPTH must be a power of two, >= 2, so the pointers wrap naturally.
import fetch_pkg::*;

module fetch_queue #(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fetch_entry_t     mem_q [DEPTH];
  fetch_entry_t     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign head  = mem_q[rd_ptr_q];

  // A pop frees the slot this same edge, so a full queue can still accept a push.
  assign do_pop  = pop && !empty;
  assign do_push = push && !flush && (!full || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      // Storage is left as-is; only the bookkeeping is cleared.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   Core front end: owns the PC, addresses a combinational instruction memory,
//   buffers {pc, instr} pairs in a prefetch queue and hands them to the decoder
//   on a valid/ready handshake. Redirects from execute flush the queue and reload
//   the PC; a HALT opcode stops fetching after it has been queued.
//   Ports:
//     clk, rst_n      : clock, asynchronous active-low reset
//     imem_addr       : instruction memory address (the PC register)
//     imem_instr      : instruction read combinationally at imem_addr
//     redirect_valid  : load redirect_pc into the PC and flush the queue
//     redirect_pc     : redirect target
//     if_valid/ready  : decoder handshake for the queue head
//     if_instr/if_pc  : queue head contents
//     halted          : fetch stopped after a HALT was queued
//     perf_fetched    : (FETCH_PERF_CNT_EN only) number of queue pushes
//     perf_redirects  : (FETCH_PERF_CNT_EN only) number of redirect cycles
//   Configuration macro: FETCH_PERF_CNT_EN adds the performance counters.
//   ADDR_W/INSTR_W must match the widths of fetch_entry_t in fetch_pkg.
import fetch_pkg::*;

module instr_fetch_unit #(
  parameter int                ADDR_W   = 16,
  parameter int                INSTR_W  = 32,
  parameter int                Q_DEPTH  = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  output logic               halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_redirects
`endif
);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              q_push;
  logic              q_pop;
  logic              q_flush;
  logic              q_full;
  logic              q_empty;
  fetch_entry_t      q_wdata;
  fetch_entry_t      q_head;

  assign q_pop   = if_valid && if_ready;
  assign q_wdata = '{pc: pc_q, instr: imem_instr};

  fetch_queue #(
    .DEPTH(Q_DEPTH)
  ) u_queue (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (q_push),
    .push_data(q_wdata),
    .pop      (q_pop),
    .flush    (q_flush),
    .head     (q_head),
    .full     (q_full),
    .empty    (q_empty)
  );

  assign imem_addr = pc_q;
  assign if_valid  = !q_empty;
  assign if_pc     = q_head.pc;
  assign if_instr  = q_head.instr;
  assign halted    = (state_q == HALTED);

  // Redirect beats everything, including a fetch that would otherwise happen
  // this cycle. The HALT instruction itself is queued; only later fetches stop.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    q_push  = 1'b0;
    q_flush = 1'b0;
    if (redirect_valid) begin
      q_flush = 1'b1;
      pc_d    = redirect_pc;
      state_d = FETCH;
    end else if (state_q == FETCH && (!q_full || q_pop)) begin
      q_push = 1'b1;
      pc_d   = pc_q + ADDR_W'(1);
      if (is_halt(imem_instr)) begin
        state_d = HALTED;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_redirects_q, perf_redirects_d;

  always_comb begin
    perf_fetched_d   = perf_fetched_q + (q_push ? 32'd1 : 32'd0);
    perf_redirects_d = perf_redirects_q + (redirect_valid ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched_q   <= '0;
      perf_redirects_q <= '0;
    end else begin
      perf_fetched_q   <= perf_fetched_d;
      perf_redirects_q <= perf_redirects_d;
    end
  end

  assign perf_fetched   = perf_fetched_q;
  assign perf_redirects = perf_redirects_q;
`endif

endmodule
